// File: rtl/spi_reg_pkg.sv
// Shared types and frame layout for the SPI register arbiter.
// Frame: [23]=write, [22:16]=addr, [15:0]=wdata.
package spi_reg_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 16;

  localparam int unsigned WR_BIT   = 23;
  localparam int unsigned ADDR_MSB = 22;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_SPI  = 1'b1
  } src_e;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-input round-robin arbiter (SPI vs host) holding last_grant.
// Ports: spi_req/host_req in, take commits grant_src; grant_valid/grant_src out.
module spi_rr_arb2 import spi_reg_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_req,
  input  logic host_req,
  input  logic take,
  output logic grant_valid,
  output src_e grant_src
);

  src_e last_grant;

  assign grant_valid = spi_req | host_req;

  // On conflict, favour whichever source was not granted last.
  assign grant_src =
    (spi_req && (!host_req || last_grant == SRC_HOST)) ?
    SRC_SPI : SRC_HOST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_HOST;
    end else if (take) begin
      last_grant <= grant_src;
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Shares a single-port register bank between decoded SPI frames and a host.
// Ports: spi_frame*/spi_rdata*/flags (SPI side), host_* (host), bank_* (bank).
// Optional SPI write protection above LOCK_BASE: define SPI_ARB_WPROT_EN.
module spi_reg_arbiter #(
  parameter int unsigned       ADDR_W    = 7,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LOCK_BASE = 7'h70
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_frame_valid,
  input  logic [23:0]       spi_frame,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rdata_valid,
  output logic              spi_ovf,
  output logic              spi_wprot_err,
  input  logic              err_clr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  import spi_reg_pkg::*;

`ifdef SPI_ARB_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  state_e            state;
  src_e              cur_src;
  src_e              grant_src;
  logic              grant_valid;
  logic              take;
  logic              spi_take;
  logic              host_cand;
  logic              blk_now;
  logic              spi_pend;
  logic              spi_wr;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_data;

  // host_req is still high during its ack cycle; don't serve it twice.
  assign host_cand = host_req & ~host_ack;
  assign take      = (state == ST_IDLE) & grant_valid;
  assign spi_take  = take & (grant_src == SRC_SPI);

  assign blk_now = WPROT_ON && (grant_src == SRC_SPI) &&
                   spi_wr && (spi_addr >= LOCK_BASE);

  spi_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_req     (spi_pend),
    .host_req    (host_cand),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  // Single-entry SPI frame latch; a frame arriving while the slot
  // drains on a grant refills it instead of overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_pend <= 1'b0;
      spi_wr   <= 1'b0;
      spi_addr <= '0;
      spi_data <= '0;
      spi_ovf  <= 1'b0;
    end else begin
      if (spi_frame_valid && (!spi_pend || spi_take)) begin
        spi_pend <= 1'b1;
        spi_wr   <= spi_frame[WR_BIT];
        spi_addr <= spi_frame[ADDR_MSB:ADDR_LSB];
        spi_data <= spi_frame[DATA_MSB:0];
      end else if (spi_take) begin
        spi_pend <= 1'b0;
      end
      if (err_clr) begin
        spi_ovf <= 1'b0;
      end else if (spi_frame_valid && spi_pend && !spi_take) begin
        spi_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cur_src         <= SRC_HOST;
      bank_en         <= 1'b0;
      bank_we         <= 1'b0;
      bank_addr       <= '0;
      bank_wdata      <= '0;
      spi_rdata       <= '0;
      spi_rdata_valid <= 1'b0;
      host_ack        <= 1'b0;
      host_rdata      <= '0;
    end else begin
      bank_en         <= 1'b0;
      spi_rdata_valid <= 1'b0;
      host_ack        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_src <= grant_src;
            if (grant_src == SRC_SPI) begin
              bank_we    <= spi_wr;
              bank_addr  <= spi_addr;
              bank_wdata <= spi_data;
            end else begin
              bank_we    <= host_we;
              bank_addr  <= host_addr;
              bank_wdata <= host_wdata;
            end
            // Blocked writes still take their slot, just no strobe.
            bank_en <= !blk_now;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (bank_we) begin
            host_ack <= (cur_src == SRC_HOST);
            state    <= ST_IDLE;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (cur_src == SRC_SPI) begin
            spi_rdata       <= bank_rdata;
            spi_rdata_valid <= 1'b1;
          end else begin
            host_rdata <= bank_rdata;
            host_ack   <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_ARB_WPROT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_wprot_err <= 1'b0;
    end else if (err_clr) begin
      spi_wprot_err <= 1'b0;
    end else if (take && blk_now) begin
      spi_wprot_err <= 1'b1;
    end
  end
`else
  assign spi_wprot_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed self-checking bench for spi_reg_arbiter with a bank model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_spi_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_frame_valid = 1'b0;
  logic [23:0] spi_frame = '0;
  logic [15:0] spi_rdata;
  logic        spi_rdata_valid;
  logic        spi_ovf;
  logic        spi_wprot_err;
  logic        err_clr = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        bank_en;
  logic        bank_we;
  logic [6:0]  bank_addr;
  logic [15:0] bank_wdata;
  logic [15:0] bank_rdata;

  logic [15:0] mem [128];
  logic        init_mem = 1'b1;
  int          en_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  spi_reg_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi_frame_valid (spi_frame_valid),
    .spi_frame       (spi_frame),
    .spi_rdata       (spi_rdata),
    .spi_rdata_valid (spi_rdata_valid),
    .spi_ovf         (spi_ovf),
    .spi_wprot_err   (spi_wprot_err),
    .err_clr         (err_clr),
    .host_req        (host_req),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_ack        (host_ack),
    .host_rdata      (host_rdata),
    .bank_en         (bank_en),
    .bank_we         (bank_we),
    .bank_addr       (bank_addr),
    .bank_wdata      (bank_wdata),
    .bank_rdata      (bank_rdata)
  );

  always #5 clk = ~clk;

  // Bank model: mem[i] = A000|i, mem[5] = BEEF; read data one cycle late.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'hA000 | 16'(i);
      mem[5] <= 16'hBEEF;
    end else if (bank_en) begin
      if (bank_we) mem[bank_addr] <= bank_wdata;
      else         bank_rdata <= mem[bank_addr];
    end
    if (bank_en) en_cnt <= en_cnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_mem = 1'b1;
    tick(2);
    tests++;
    if ({spi_rdata, spi_rdata_valid, spi_ovf, spi_wprot_err, host_ack,
         host_rdata, bank_en, bank_we, bank_addr, bank_wdata} !== 61'h0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    rst_n = 1'b1;
    init_mem = 1'b0;
    tick();
    tests++;
    if ({spi_rdata_valid, host_ack, bank_en, spi_ovf} !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 0000",
               {spi_rdata_valid, host_ack, bank_en, spi_ovf});
    end
  endtask

  task automatic test_spi_read();
    spi_frame = 24'h05_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    tick();
    tests++;
    if ({bank_en, bank_we, bank_addr} !== {1'b1, 1'b0, 7'h05}) begin
      fails++;
      $display("FAIL spi_rd_access: got en/we/addr %b/%b/%h want 1/0/05",
               bank_en, bank_we, bank_addr);
    end
    tick();
    tests++;
    if (spi_rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL spi_rd_early: got valid %b want 0", spi_rdata_valid);
    end
    tick();
    tests++;
    if ({spi_rdata_valid, spi_rdata} !== {1'b1, 16'hBEEF}) begin
      fails++;
      $display("FAIL spi_rd_data: got %b/%h want 1/beef",
               spi_rdata_valid, spi_rdata);
    end
    tick();
    tests++;
    if (spi_rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL spi_rd_pulse: got valid %b want 0", spi_rdata_valid);
    end
  endtask

  task automatic test_host_wr_rd();
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 7'h12;
    host_wdata = 16'h1234;
    tick();
    tests++;
    if ({bank_en, bank_we, bank_addr, bank_wdata} !==
        {1'b1, 1'b1, 7'h12, 16'h1234}) begin
      fails++;
      $display("FAIL host_wr_access: got %b/%b/%h/%h want 1/1/12/1234",
               bank_en, bank_we, bank_addr, bank_wdata);
    end
    tick();
    tests++;
    if (host_ack !== 1'b1) begin
      fails++;
      $display("FAIL host_wr_ack: got %b want 1", host_ack);
    end
    tick();
    tests++;
    if ({host_ack, bank_en} !== 2'b00) begin
      fails++;
      $display("FAIL host_no_regrant: got ack/en %b want 00",
               {host_ack, bank_en});
    end
    host_req = 1'b0;
    tick();
    tests++;
    if (mem[7'h12] !== 16'h1234) begin
      fails++;
      $display("FAIL host_wr_mem: got %h want 1234", mem[7'h12]);
    end
    host_we = 1'b0;
    host_req = 1'b1;
    tick();
    tests++;
    if ({bank_en, bank_we, bank_addr} !== {1'b1, 1'b0, 7'h12}) begin
      fails++;
      $display("FAIL host_rd_access: got %b/%b/%h want 1/0/12",
               bank_en, bank_we, bank_addr);
    end
    tick();
    tests++;
    if (host_ack !== 1'b0) begin
      fails++;
      $display("FAIL host_rd_early: got ack %b want 0", host_ack);
    end
    tick();
    tests++;
    if ({host_ack, host_rdata} !== {1'b1, 16'h1234}) begin
      fails++;
      $display("FAIL host_rd_data: got %b/%h want 1/1234",
               host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    spi_frame = 24'h03_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 7'h04;
    tick();
    tests++;
    if ({bank_en, bank_addr} !== {1'b1, 7'h03}) begin
      fails++;
      $display("FAIL conflict_spi_first: got en/addr %b/%h want 1/03",
               bank_en, bank_addr);
    end
    spi_frame = 24'h06_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    tick();
    tests++;
    if ({spi_rdata_valid, spi_rdata} !== {1'b1, 16'hA003}) begin
      fails++;
      $display("FAIL conflict_spi_data: got %b/%h want 1/a003",
               spi_rdata_valid, spi_rdata);
    end
    tick();
    tests++;
    if ({bank_en, bank_addr} !== {1'b1, 7'h04}) begin
      fails++;
      $display("FAIL conflict_host_next: got en/addr %b/%h want 1/04",
               bank_en, bank_addr);
    end
    tick(2);
    tests++;
    if ({host_ack, host_rdata} !== {1'b1, 16'hA004}) begin
      fails++;
      $display("FAIL conflict_host_data: got %b/%h want 1/a004",
               host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick();
    tests++;
    if ({bank_en, bank_addr} !== {1'b1, 7'h06}) begin
      fails++;
      $display("FAIL conflict_spi_after: got en/addr %b/%h want 1/06",
               bank_en, bank_addr);
    end
    tick(2);
    tests++;
    if ({spi_rdata_valid, spi_rdata} !== {1'b1, 16'hA006}) begin
      fails++;
      $display("FAIL conflict_spi2_data: got %b/%h want 1/a006",
               spi_rdata_valid, spi_rdata);
    end
  endtask

  task automatic test_back_to_back();
    spi_frame = 24'hA0_1111;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame = 24'hA1_2222;
    tick();
    spi_frame_valid = 1'b0;
    tests++;
    if ({spi_ovf, bank_en, bank_we, bank_addr, bank_wdata} !==
        {1'b0, 1'b1, 1'b1, 7'h20, 16'h1111}) begin
      fails++;
      $display("FAIL b2b_first: got ovf/en/we/addr/wd %b/%b/%b/%h/%h want 0/1/1/20/1111",
               spi_ovf, bank_en, bank_we, bank_addr, bank_wdata);
    end
    tick();
    tests++;
    if ({bank_en, spi_rdata_valid, mem[7'h20]} !== {2'b00, 16'h1111}) begin
      fails++;
      $display("FAIL b2b_gap: got en/valid/mem %b/%b/%h want 0/0/1111",
               bank_en, spi_rdata_valid, mem[7'h20]);
    end
    tick();
    tests++;
    if ({bank_en, bank_we, bank_addr, bank_wdata} !==
        {1'b1, 1'b1, 7'h21, 16'h2222}) begin
      fails++;
      $display("FAIL b2b_second: got %b/%b/%h/%h want 1/1/21/2222",
               bank_en, bank_we, bank_addr, bank_wdata);
    end
    tick();
    tests++;
    if ({spi_rdata_valid, spi_ovf, mem[7'h21]} !== {2'b00, 16'h2222}) begin
      fails++;
      $display("FAIL b2b_done: got valid/ovf/mem %b/%b/%h want 0/0/2222",
               spi_rdata_valid, spi_ovf, mem[7'h21]);
    end
  endtask

  task automatic test_overflow();
    int c;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 7'h09;
    tick();
    spi_frame = 24'h01_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame = 24'h02_0000;
    tick();
    spi_frame_valid = 1'b0;
    tests++;
    if ({spi_ovf, host_ack, host_rdata} !== {2'b11, 16'hA009}) begin
      fails++;
      $display("FAIL ovf_set: got ovf/ack/rdata %b/%b/%h want 1/1/a009",
               spi_ovf, host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick();
    tests++;
    if ({bank_en, bank_addr} !== {1'b1, 7'h01}) begin
      fails++;
      $display("FAIL ovf_kept_first: got en/addr %b/%h want 1/01",
               bank_en, bank_addr);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (spi_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", spi_ovf);
    end
    tick();
    tests++;
    if ({spi_rdata_valid, spi_rdata} !== {1'b1, 16'hA001}) begin
      fails++;
      $display("FAIL ovf_first_data: got %b/%h want 1/a001",
               spi_rdata_valid, spi_rdata);
    end
    c = en_cnt;
    tick(3);
    tests++;
    if (en_cnt !== c) begin
      fails++;
      $display("FAIL ovf_dropped: got %0d extra accesses want 0", en_cnt - c);
    end
  endtask

  task automatic test_err_clr_priority();
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 7'h08;
    tick();
    spi_frame = 24'h02_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame = 24'h03_0000;
    err_clr = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    err_clr = 1'b0;
    tests++;
    if ({spi_ovf, host_ack, host_rdata} !== {2'b01, 16'hA008}) begin
      fails++;
      $display("FAIL clr_priority: got ovf/ack/rdata %b/%b/%h want 0/1/a008",
               spi_ovf, host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick(3);
    tests++;
    if ({spi_rdata_valid, spi_rdata} !== {1'b1, 16'hA002}) begin
      fails++;
      $display("FAIL clr_kept_first: got %b/%h want 1/a002",
               spi_rdata_valid, spi_rdata);
    end
  endtask

  task automatic test_wprot();
    int c;
    c = en_cnt;
    spi_frame = 24'hF0_AAAA;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    tick();
`ifdef SPI_ARB_WPROT_EN
    tests++;
    if ({bank_en, spi_wprot_err} !== 2'b01) begin
      fails++;
      $display("FAIL wprot_block: got en/err %b want 01",
               {bank_en, spi_wprot_err});
    end
    tick(2);
    tests++;
    if ({en_cnt - c, mem[7'h70]} !== {32'd0, 16'hA070}) begin
      fails++;
      $display("FAIL wprot_no_write: got accesses %0d mem %h want 0 a070",
               en_cnt - c, mem[7'h70]);
    end
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 7'h70;
    host_wdata = 16'h5555;
    tick();
    tests++;
    if ({bank_en, bank_we, bank_addr} !== {2'b11, 7'h70}) begin
      fails++;
      $display("FAIL wprot_host_access: got %b/%b/%h want 1/1/70",
               bank_en, bank_we, bank_addr);
    end
    tick();
    host_req = 1'b0;
    tests++;
    if ({host_ack, mem[7'h70]} !== {1'b1, 16'h5555}) begin
      fails++;
      $display("FAIL wprot_host_write: got ack/mem %b/%h want 1/5555",
               host_ack, mem[7'h70]);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (spi_wprot_err !== 1'b0) begin
      fails++;
      $display("FAIL wprot_clear: got %b want 0", spi_wprot_err);
    end
`else
    tests++;
    if ({bank_en, bank_addr, spi_wprot_err} !== {1'b1, 7'h70, 1'b0}) begin
      fails++;
      $display("FAIL noprot_access: got en/addr/err %b/%h/%b want 1/70/0",
               bank_en, bank_addr, spi_wprot_err);
    end
    tick();
    tests++;
    if ({en_cnt - c, mem[7'h70]} !== {32'd1, 16'hAAAA}) begin
      fails++;
      $display("FAIL noprot_write: got accesses %0d mem %h want 1 aaaa",
               en_cnt - c, mem[7'h70]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int acks;
    int ens;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 7'h0A;
    tick();
    spi_frame = 24'h0B_0000;
    spi_frame_valid = 1'b1;
    tick();
    spi_frame_valid = 1'b0;
    rst_n = 1'b0;
    host_req = 1'b0;
    #1;
    tests++;
    if ({spi_rdata, spi_rdata_valid, spi_ovf, spi_wprot_err, host_ack,
         host_rdata, bank_en, bank_we, bank_addr, bank_wdata} !== 61'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got nonzero outputs, want all 0");
    end
    tick();
    rst_n = 1'b1;
    acks = 0;
    ens = 0;
    repeat (6) begin
      tick();
      if (host_ack || spi_rdata_valid) acks++;
      if (bank_en) ens++;
    end
    tests++;
    if (acks !== 0 || ens !== 0) begin
      fails++;
      $display("FAIL midreset_quiet: got acks %0d accesses %0d want 0 0",
               acks, ens);
    end
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 7'h30;
    host_wdata = 16'h3333;
    tick();
    tests++;
    if ({bank_en, bank_addr} !== {1'b1, 7'h30}) begin
      fails++;
      $display("FAIL midreset_idle: got en/addr %b/%h want 1/30",
               bank_en, bank_addr);
    end
    tick();
    host_req = 1'b0;
    tests++;
    if (host_ack !== 1'b1) begin
      fails++;
      $display("FAIL midreset_ack: got %b want 1", host_ack);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_spi_read();
    test_host_wr_rd();
    test_conflict();
    test_back_to_back();
    test_overflow();
    test_err_clr_priority();
    test_wprot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_arbiter.md
Name: spi_reg_arbiter

Overview:
- Clock-domain controller behind the 24-bit SPI slave: owns the single-port register bank and shares it between SPI-decoded frames and a local host port.
- Accepts one decoded SPI frame per pulse and arbitrates it round-robin against host requests.
- Sequences one bank access at a time and returns read data to the SPI slave for the next MISO frame, and to the host.

Parameters:
- ADDR_W, 7, register bank address width (SPI frame carries 7 address bits).
- DATA_W, 16, register data width (SPI frame carries 16 data bits).
- LOCK_BASE, 7'h70, first SPI-write-protected address (used only with SPI_ARB_WPROT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spi_frame_valid  input  1  one-cycle pulse: a complete 24-bit frame is on spi_frame, already synchronised to clk.
- spi_frame  input  24  [23]=write, [22:16]=addr, [15:0]=wdata (ignored for reads).
- spi_rdata  output  16  read data for the SPI slave's next MISO load.
- spi_rdata_valid  output  1  one-cycle pulse when spi_rdata is updated.
- spi_ovf  output  1  sticky: an SPI frame was dropped.
- spi_wprot_err  output  1  sticky: SPI write to a protected address was blocked (tied 0 without the macro).
- err_clr  input  1  clears spi_ovf and spi_wprot_err.
- host_req  input  1  level request; held until host_ack.
- host_we  input  1  host write enable; stable while host_req is high.
- host_addr  input  7  host address; stable while host_req is high.
- host_wdata  input  16  host write data; stable while host_req is high.
- host_ack  output  1  one-cycle completion pulse.
- host_rdata  output  16  read data; valid with host_ack.
- bank_en  output  1  bank access strobe.
- bank_we  output  1  bank write.
- bank_addr  output  7  bank address.
- bank_wdata  output  16  bank write data.
- bank_rdata  input  16  bank read data, valid the cycle after bank_en with bank_we=0.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; spi_pend=0; last_grant=HOST, so SPI wins the first conflict.
- SPI pending latch:
  - spi_frame_valid with spi_pend=0: capture the frame and set spi_pend.
  - spi_frame_valid with spi_pend=1: drop the new frame and set spi_ovf. The pending frame is kept.
  - spi_frame_valid in the same cycle spi_pend is being cleared (grant cycle): accept the new frame; no overflow.
- FSM states: IDLE, ACCESS, CAPTURE.
  - IDLE:
    - Candidates are spi_pend and host_req.
    - One candidate: grant it.
    - Both: grant the one not equal to last_grant.
    - On grant: update last_grant, load the bank_* registers, go to ACCESS.
    - A granted SPI frame clears spi_pend.
  - ACCESS:
    - bank_en=1 for exactly this cycle.
    - Write: go to IDLE and pulse the requester completion.
    - Read: go to CAPTURE.
  - CAPTURE:
    - Register bank_rdata into spi_rdata or host_rdata.
    - Pulse spi_rdata_valid or host_ack.
    - Go to IDLE.
- Completion pulses:
  - Host write: host_ack pulses in the cycle after ACCESS.
  - SPI write: no spi_rdata_valid pulse.
- Latency from grant edge: write = 2 cycles to host_ack; read = 3 cycles to host_ack or spi_rdata_valid.
  - Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- host_ack pulses for exactly one cycle. The host must drop or change host_req on the cycle after host_ack; re-arbitration occurs in IDLE.
- err_clr has priority over a same-cycle set of spi_ovf or spi_wprot_err; both flags read 0 the next cycle.
- Asynchronous reset mid-access: the transaction is abandoned, no ack is issued, and a pending SPI frame is lost.

Optional Feature:
- Macro: SPI_ARB_WPROT_EN.
- Defined:
  - An SPI write with addr >= LOCK_BASE is granted normally (still consumes its arbitration slot and still updates last_grant).
  - bank_en stays 0 in ACCESS.
  - spi_wprot_err is set.
  - Host writes are never blocked.
- Undefined: no address check; spi_wprot_err is tied 0.

Decomposition:
- Package spi_reg_pkg:
  - frame bit positions: WR_BIT=23, ADDR_MSB=22, ADDR_LSB=16, DATA_MSB=15.
  - ADDR_W, DATA_W.
  - FSM state encodings.
  - grant-source encoding: SRC_HOST=0, SRC_SPI=1.
- One natural sub-module: spi_rr_arb2, a 2-input round-robin arbiter holding last_grant.

Test Plan:
- SPI read: spi_frame=24'h05_0000 (addr 5) with bank[5]=16'hBEEF → bank_en, bank_addr=5, bank_we=0; spi_rdata=16'hBEEF with a spi_rdata_valid pulse 3 cycles after grant.
- Host write then read: addr 7'h12, wdata 16'h1234 → host_ack 2 cycles after grant; a following read returns host_rdata=16'h1234.
- Simultaneous SPI read addr 3 and host read addr 4 out of reset → SPI served first. Repeat the conflict → host served first (alternation).
- Two spi_frame_valid pulses 1 cycle apart while a host read is in ACCESS → first frame kept, second dropped, spi_ovf=1. err_clr → spi_ovf=0 next cycle.
- With SPI_ARB_WPROT_EN: SPI write 24'hF0_AAAA (addr 7'h70) → bank_en never asserted, spi_wprot_err=1. A host write to addr 7'h70 succeeds.
- rst_n asserted during CAPTURE → all outputs 0 immediately; no ack after release; FSM in IDLE.
